// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: launches one access per request, waits for mem_done or timeout, then sequences halt/dump.
// Latency: launch, at least 1 wait cycle, then 1 done cycle; stall covers the launch and wait cycles.
module mem_stage_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int TIMEOUT   = 31,
    parameter bit ALIGN_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              halt,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              stall,
    output logic              err,
    output logic              createdump,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_DONE   = 3'd2,
        S_DUMP   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_halt_pend;
    logic                r_is_read;
    logic [DATA_W-1:0]   r_read_data;
    logic                r_err;

    logic                w_launch;
    logic                w_bad_req;
    logic                w_timeout;

    assign w_launch  = (r_state == S_IDLE) && (memRead ^ memWrite) && !(ALIGN_CHK && addr[0]);
    assign w_bad_req = (r_state == S_IDLE) && (memRead || memWrite) && !w_launch;
    // A done pulse in the same cycle as the counter limit takes priority.
    assign w_timeout = (r_state == S_WAIT) && !mem_done && (r_cnt == CNT_W'(TIMEOUT));

    assign readData = r_read_data;
    assign err      = r_err;

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        createdump  = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    mem_en      = 1'b1;
                    mem_wr      = memWrite;
                    mem_addr    = addr;
                    mem_wdata   = writeData;
                    stall       = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (halt) begin
                    w_state_nxt = S_DUMP;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (mem_done || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:   w_state_nxt = r_halt_pend ? S_DUMP : S_IDLE;
            S_DUMP: begin
                createdump  = 1'b1;
                w_state_nxt = S_HALTED;
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_halt_pend <= 1'b0;
            r_is_read   <= 1'b0;
            r_read_data <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_cnt       <= '0;
                r_halt_pend <= halt;
                r_is_read   <= memRead;
            end else if ((r_state == S_WAIT) && !mem_done && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_WAIT) && mem_done && r_is_read) begin
                r_read_data <= mem_rdata;
            end else if (w_timeout && r_is_read) begin
                r_read_data <= '0;
            end
            if (w_bad_req || w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: stimulus pushes expected launches, completions and dumps; a monitor pops and compares.
module tb_mem_stage_ctrl;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          memRead;
    logic          memWrite;
    logic          halt;
    logic [AW-1:0] addr;
    logic [DW-1:0] writeData;
    logic [DW-1:0] readData;
    logic          stall;
    logic          err;
    logic          createdump;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;

    mem_stage_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO), .ALIGN_CHK(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .halt(halt),
        .addr(addr), .writeData(writeData), .readData(readData), .stall(stall),
        .err(err), .createdump(createdump), .mem_en(mem_en), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_done(mem_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } launch_t;
    typedef struct {
        logic [DW-1:0] rd;
        logic          er;
        int            len;
    } done_t;

    launch_t exp_launch[$];
    done_t   exp_done[$];
    int      exp_dump[$];

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] mm      [logic [AW-1:0]];
    logic [DW-1:0] ref_rd;
    logic          ref_err;
    bit            halted;
    bit            mon_on = 1'b0;
    int            next_lat = 1;
    int            inject_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return DW'(a) ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] ref_load(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memory model: responds next_lat cycles after a launch; next_lat==0 means never.
    initial begin : memory_model
        int lat;
        int seen;
        logic [DW-1:0] rdv;
        seen = 0;
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_en && next_lat != 0) begin
                lat = next_lat;
                if (mem_wr) mm[mem_addr] = mem_wdata;
                rdv = mm.exists(mem_addr) ? mm[mem_addr] : dflt(mem_addr);
                repeat (lat) @(posedge clk);
                #1 mem_done = 1'b1; mem_rdata = rdv;
                @(posedge clk);
                #1 mem_done = 1'b0; mem_rdata = DW'($urandom);
            end else if (inject_cnt != seen) begin
                seen++;
                @(posedge clk);
                #1 mem_done = 1'b1; mem_rdata = 16'hDEAD;
                @(posedge clk);
                #1 mem_done = 1'b0;
            end
        end
    end

    initial begin : monitor
        int run;
        launch_t l;
        done_t dn;
        int dc;
        run = 0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (mem_en) begin
                    check("launch_expected", exp_launch.size() > 0, 1);
                    if (exp_launch.size() > 0) begin
                        l = exp_launch.pop_front();
                        check("launch_wr", mem_wr, l.wr);
                        check("launch_addr", mem_addr, l.a);
                        check("launch_wdata", mem_wdata, l.d);
                    end
                end else begin
                    check("mem_outputs_zero", (mem_wr || mem_addr != '0 || mem_wdata != '0), 0);
                end
                if (stall) begin
                    run++;
                end else if (run > 0) begin
                    check("done_expected", exp_done.size() > 0, 1);
                    if (exp_done.size() > 0) begin
                        dn = exp_done.pop_front();
                        check("stall_cycles", run, dn.len);
                        check("done_readData", readData, dn.rd);
                        check("done_err", err, dn.er);
                    end
                    run = 0;
                end
                if (createdump) begin
                    check("dump_expected", exp_dump.size() > 0, 1);
                    if (exp_dump.size() > 0) begin
                        dc = exp_dump.pop_front();
                        check("dump_cycle", cyc, dc);
                    end
                    check("dump_stall_low", stall, 0);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0; next_lat = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_rd = '0; ref_err = 1'b0; halted = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check("reset_stall", stall, 0);
        check("reset_readData", readData, 0);
        check("reset_err", err, 0);
        check("reset_createdump", createdump, 0);
        check("reset_mem_en", mem_en, 0);
    endtask

    // One pipeline request held for a single cycle; returns once the block is idle again.
    task automatic do_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic h, input int lat);
        int c;
        int k;
        int span;
        logic ok;
        logic valid;
        launch_t l;
        done_t dn;
        @(posedge clk); #1;
        c = cyc;
        next_lat = lat; memRead = rd; memWrite = wr; addr = a; writeData = d; halt = h;
        valid = (rd != wr) && (a[0] == 1'b0);
        span = 1;
        if (valid) begin
            ok = (lat >= 1) && (lat <= TO + 1);
            k = ok ? lat : TO + 1;
            l.wr = wr; l.a = a; l.d = d;
            exp_launch.push_back(l);
            if (ok && wr) ref_mem[a] = d;
            if (rd) ref_rd = ok ? ref_load(a) : '0;
            if (!ok) ref_err = 1'b1;
            dn.rd = ref_rd; dn.er = ref_err; dn.len = k + 1;
            exp_done.push_back(dn);
            span = k + 2;
            if (h) begin exp_dump.push_back(c + k + 2); halted = 1'b1; end
        end else begin
            if (rd || wr) ref_err = 1'b1;
            if (h) begin exp_dump.push_back(c + 1); halted = 1'b1; end
        end
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
        addr = AW'($urandom); writeData = DW'($urandom);
        repeat (span - 1) @(posedge clk);
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_err"}, err, ref_err);
        check({tag, "_readData"}, readData, ref_rd);
    endtask

    initial begin : stimulus
        int r;
        int lat;
        logic [AW-1:0] a;
        rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
        addr = '0; writeData = '0;
        ref_rd = '0; ref_err = 1'b0; halted = 1'b0;
        do_reset();

        do_op(0, 1, 16'h0010, 16'hBEEF, 0, 1);
        do_op(1, 0, 16'h0010, 16'h0000, 0, 2);
        check_state("load_beef");
        do_op(0, 1, 16'h0020, 16'h1234, 0, 3);
        check_state("store_keeps_readData");
        do_op(1, 0, 16'h0020, 16'h0000, 0, 1);
        check_state("load_1234");
        do_op(1, 0, 16'h0020, 16'h0000, 0, TO + 1);
        check_state("done_at_timeout_limit");

        do_op(1, 0, 16'h0003, 16'h0000, 0, 1);
        check_state("unaligned_read");
        do_op(1, 1, 16'h0004, 16'h7777, 0, 1);
        check_state("read_write_conflict");

        do_op(1, 0, 16'h0030, 16'h0000, 0, 0);
        check_state("timeout_read");
        inject_cnt++;
        repeat (4) @(posedge clk);
        check_state("late_done_in_idle");
        check("late_done_stall", stall, 0);

        do_op(1, 0, 16'h0010, 16'h0000, 0, 2);
        check_state("load_before_reset");
        @(posedge clk); #1;
        next_lat = 0; memRead = 1'b1; addr = 16'h0040; writeData = '0;
        begin
            launch_t l;
            done_t dn;
            l.wr = 1'b0; l.a = 16'h0040; l.d = '0;
            exp_launch.push_back(l);
            dn.rd = '0; dn.er = 1'b0; dn.len = 3;
            exp_done.push_back(dn);
        end
        @(posedge clk); #1;
        memRead = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_rd = '0; ref_err = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_readData", readData, 0);
        check("rst_mid_err", err, 0);
        inject_cnt++;
        repeat (4) @(posedge clk);
        check_state("late_done_after_reset");
        do_op(1, 0, 16'h0020, 16'h0000, 0, 1);
        check_state("load_after_reset");

        do_op(0, 1, 16'h0050, 16'hCAFE, 1, 1);
        check_state("halt_with_store");
        repeat (2) @(posedge clk);
        #1 memRead = 1'b1; addr = 16'h0060;
        repeat (5) begin
            @(negedge clk);
            check("halted_stall", stall, 0);
            check("halted_mem_en", mem_en, 0);
        end
        @(posedge clk); #1 memRead = 1'b0;

        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 99);
                lat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, TO + 1);
                a = AW'($urandom_range(0, 15)) << 1;
                if (r < 45)      do_op(1, 0, a, DW'($urandom), ($urandom_range(0, 29) == 0), lat);
                else if (r < 88) do_op(0, 1, a, DW'($urandom), ($urandom_range(0, 29) == 0), lat);
                else if (r < 92) do_op(1, 1, a, DW'($urandom), 0, lat);
                else if (r < 96) do_op(1, 0, a | 16'h0001, DW'($urandom), 0, lat);
                else             do_op(0, 0, a, DW'($urandom), ($urandom_range(0, 3) == 0), lat);
                check_state("random");
                if (halted) break;
            end
            repeat (3) @(posedge clk);
        end

        repeat (8) @(posedge clk);
        check("launch_queue_drained", exp_launch.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);
        check("dump_queue_drained", exp_dump.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
